// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the memory stage.
// Data-first arbitration with a fetch starvation guard and a flush-cancellable fetch.
module mem_port_arbiter #(
   parameter int MAX_DEFER = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_valid,
   output logic [31:0] if_instr,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        stall_f,
   output logic        stall_m,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam int CNT_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);
   localparam logic [CNT_W-1:0] DEFER_MAX = CNT_W'(MAX_DEFER);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] defer_cnt;
   logic             discard;
   logic             f_eff, f_arb, d_arb, defer_full;
   logic             grant_f, grant_d;

   // A requester whose completion pulse is out this cycle is not re-arbitrated.
   assign f_eff      = if_req & ~if_flush;
   assign f_arb      = f_eff & ~if_valid;
   assign d_arb      = d_req & ~d_done;
   assign defer_full = (defer_cnt == DEFER_MAX);

   assign stall_f = if_req & ~if_valid & ~if_flush;
   assign stall_m = d_req & ~d_done;

   always_comb begin
      state_d = state_q;
      grant_f = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (f_arb && (!d_arb || defer_full)) begin
               grant_f = 1'b1;
               state_d = FETCH;
            end else if (d_arb) begin
               grant_d = 1'b1;
               state_d = DATA;
            end
         end
         FETCH, DATA: begin
            if (mem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_valid  <= 1'b0;
         if_instr  <= '0;
         d_done    <= 1'b0;
         d_rdata   <= '0;
         defer_cnt <= '0;
         discard   <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_done   <= 1'b0;

         if (grant_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            defer_cnt <= '0;
         end

         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (f_eff && !defer_full) defer_cnt <= defer_cnt + CNT_W'(1);
         end

         // A flush seen on any fetch cycle, the ack cycle included, drops the word.
         if (state_q == FETCH) begin
            if (mem_ack) begin
               mem_req <= 1'b0;
               discard <= 1'b0;
               if (!discard && !if_flush) begin
                  if_instr <= mem_rdata;
                  if_valid <= 1'b1;
               end
            end else if (if_flush) begin
               discard <= 1'b1;
            end
         end

         if (state_q == DATA && mem_ack) begin
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
         end
      end
   end
endmodule
